wb_mem_arbiter: RTL and testbench
=================================

Name: wb_mem_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter in front of the shared simulation/SoC memory.
- Master 0 is the d$/LSU port; master 1 is the I$ port.
- Grants one master at a time with round-robin fairness and rebases core addresses (ADDR_BASE) to memory offsets.
- Range-checks addresses and enforces a per-access ack timeout, answering bad or hung accesses with err.

Parameters:
- ADDR_BASE, 32'h8000_0000, core address mapped to memory offset 0
- MEM_BYTES, 65536, size of the memory window in bytes
- TIMEOUT, 256, cycles of slave stb without ack before the access is aborted (minimum 2)
- CNT_W, $clog2(TIMEOUT)+1, timeout counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_adr_i, m1_adr_i  in  32  master byte address
- m0_dat_i, m1_dat_i  in  32  master write data
- m0_sel_i, m1_sel_i  in  4  byte selects
- m0_we_i, m1_we_i  in  1  write enable
- m0_cyc_i, m1_cyc_i  in  1  bus cycle
- m0_stb_i, m1_stb_i  in  1  strobe
- m0_dat_o, m1_dat_o  out  32  read data
- m0_ack_o, m1_ack_o  out  1  ack
- m0_err_o, m1_err_o  out  1  error
- s_adr_o  out  32  rebased offset (master adr − ADDR_BASE)
- s_dat_o  out  32  write data
- s_sel_o  out  4  byte selects
- s_we_o  out  1  write enable
- s_cyc_o  out  1  bus cycle
- s_stb_o  out  1  strobe
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  2  one-hot current grant, for debug

Behaviour:
- Reset (synchronous):
  - State IDLE, grant_o=0, last=1 so m0 wins the first tie, timeout counter 0.
  - All s_* outputs 0; all m*_ack/err/dat outputs 0.
  - Reset asserted mid-access drops s_cyc_o on the next edge; no ack or err is delivered for that access.
- States: IDLE, G0, G1, ERR.
- Leaving IDLE:
  - Only m0_cyc high → G0; only m1_cyc high → G1.
  - Both high → grant the master ≠ last.
  - Arbitration latency is one cycle: the grant is registered, and slave outputs follow the granted master combinationally from the first G0/G1 cycle.
- Grant hold: a grant persists while the granted master's cyc stays high, so back-to-back strobes inside one cyc are not preempted.
  - When the granted cyc falls → IDLE, and last takes the granted index.
  - At least one IDLE cycle between grants.
- Address rebase and range check:
  - s_adr_o = adr − ADDR_BASE, modulo 2^32.
  - Legal iff adr ≥ ADDR_BASE and (adr − ADDR_BASE) < MEM_BYTES.
  - Illegal address with stb high: s_stb_o stays 0 and the state goes to ERR.
- Routing:
  - Slave ack and data go only to the granted master; the non-granted master sees ack=0, err=0, dat=0.
  - m*_ack_o = s_ack_i & granted & legal.
- Timeout:
  - The counter increments each cycle s_stb_o=1 and s_ack_i=0.
  - It clears on ack or on a grant change.
  - When it reaches TIMEOUT−1 without ack → ERR.
- ERR (exactly one cycle):
  - err_o=1 to the granted master; s_cyc_o=s_stb_o=0.
  - Then back to the same grant state if that master's cyc is still high, else IDLE.
  - A late s_ack_i arriving in ERR is ignored.
- Simultaneous events:
  - Ack in the same cycle the counter hits TIMEOUT−1: the ack wins, no err.
  - Granted cyc falling while the other master requests: IDLE for one cycle, then the other master is granted.

Decomposition:
- Shared package wb_pkg:
  - wb_req_t struct {adr, dat, sel, we, cyc, stb}.
  - wb_rsp_t struct {dat, ack, err}.
  - Arbiter state enum.
  - Default ADDR_BASE and MEM_BYTES constants, also used by the memory model and the bench.
- One sub-module, wb_rr_pick: a combinational 2-way round-robin picker taking the requests and last, returning a one-hot grant.

Test Plan:
- Single m1 read at 0x8000_0010, slave acks after 1 cycle → s_adr_o=0x10 during G1; m1_ack_o for 1 cycle with m1_dat_o=s_dat_i; m0_ack_o stays 0.
- m0 and m1 raise cyc on the same cycle right after reset → G0 first; after m0 drops cyc, one IDLE cycle, then G1; the next simultaneous request goes to m0.
- m0 holds cyc over 4 strobes while m1 is requesting → no preemption; grant_o=01 throughout; m1 is granted 2 cycles after m0's cyc falls.
- m0 write to 0x8001_0000 (MEM_BYTES=65536) → s_stb_o never asserted; m0_err_o pulses once; grant is held.
- m0 write to 0x7FFF_FFFC → below ADDR_BASE, so s_stb_o is never asserted and m0_err_o pulses once.
- Slave never acks, TIMEOUT=8 → err on the 9th cycle after stb; s_cyc_o is 0 that cycle.
- Ack at counter TIMEOUT−1 → ack, no err.
- Reset asserted while in G1 with stb pending → next cycle: all outputs 0, grant_o=0; no ack or err is delivered afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone types and memory-window defaults for the arbiter, the memory model and the bench.
package wb_pkg;

   localparam logic [31:0] DEF_ADDR_BASE = 32'h8000_0000;
   localparam int          DEF_MEM_BYTES = 65536;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
      logic        cyc;
      logic        stb;
   } wb_req_t;

   typedef struct packed {
      logic [31:0] dat;
      logic        ack;
      logic        err;
   } wb_rsp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G0   = 2'd1,
      ST_G1   = 2'd2,
      ST_ERR  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way round-robin picker: on a tie the master that was not served last wins.
module wb_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of the shared memory: round-robin grant,
// address rebase, window range check and per-access ack timeout.
module wb_mem_arbiter
   import wb_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
   parameter int          MEM_BYTES = DEF_MEM_BYTES,
   parameter int          TIMEOUT   = 256,
   parameter int          CNT_W     = $clog2(TIMEOUT) + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  grant_o
);

   localparam logic [31:0]      MEM_LIM  = 32'(MEM_BYTES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t       state_reg, state_next;
   logic             cur_reg, cur_next;
   logic             last_reg;
   logic [CNT_W-1:0] cnt_reg;

   wb_req_t     req [2];
   wb_rsp_t     rsp [2];
   wb_req_t     sel_req;
   logic [1:0]  pick;
   logic [31:0] offset;
   logic        legal;
   logic        granted;

   assign req[0] = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i, cyc: m0_cyc_i, stb: m0_stb_i};
   assign req[1] = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i, cyc: m1_cyc_i, stb: m1_stb_i};

   wb_rr_pick u_pick (
      .req   ({m1_cyc_i, m0_cyc_i}),
      .last  (last_reg),
      .grant (pick)
   );

   assign sel_req = req[cur_reg];
   assign offset  = sel_req.adr - ADDR_BASE;
   assign legal   = (sel_req.adr >= ADDR_BASE) && (offset < MEM_LIM);
   assign granted = (state_reg == ST_G0) || (state_reg == ST_G1);

   // Slave side is quiet outside a grant, including the one-cycle ERR response.
   assign s_cyc_o = granted & sel_req.cyc;
   assign s_stb_o = granted & sel_req.stb & legal;
   assign s_adr_o = granted ? offset : 32'h0;
   assign s_dat_o = granted ? sel_req.dat : 32'h0;
   assign s_sel_o = granted ? sel_req.sel : 4'h0;
   assign s_we_o  = granted & sel_req.we;

   assign grant_o = (state_reg == ST_IDLE) ? 2'b00 : (cur_reg ? 2'b10 : 2'b01);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
         logic mine;
         assign mine        = (cur_reg == 1'(gi));
         assign rsp[gi].dat = (granted && mine) ? s_dat_i : 32'h0;
         assign rsp[gi].ack = granted & mine & legal & s_ack_i;
         assign rsp[gi].err = (state_reg == ST_ERR) & mine;
      end
   endgenerate

   assign {m0_dat_o, m0_ack_o, m0_err_o} = rsp[0];
   assign {m1_dat_o, m1_ack_o, m1_err_o} = rsp[1];

   always_comb begin
      state_next = state_reg;
      cur_next   = cur_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pick != 2'b00) begin
               cur_next   = pick[1];
               state_next = pick[1] ? ST_G1 : ST_G0;
            end
         end
         ST_G0, ST_G1: begin
            if (!sel_req.cyc) begin
               state_next = ST_IDLE;
            end else if (sel_req.stb && !legal) begin
               state_next = ST_ERR;
            end else if (s_stb_o && !s_ack_i && (cnt_reg == CNT_LAST)) begin
               state_next = ST_ERR;
            end
         end
         default: begin
            state_next = sel_req.cyc ? (cur_reg ? ST_G1 : ST_G0) : ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cur_reg   <= 1'b0;
         last_reg  <= 1'b1;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cur_reg   <= cur_next;
         if ((state_reg != ST_IDLE) && (state_next == ST_IDLE)) begin
            last_reg <= cur_reg;
         end
         // Any state change (grant change or abort) restarts the timeout window.
         if (s_ack_i || (state_next != state_reg)) begin
            cnt_reg <= '0;
         end else if (s_stb_o) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: the bench plays both masters and the slave cycle by cycle.
module tb_wb_mem_arbiter;
   import wb_pkg::*;

   logic        clk, reset;
   logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
   logic [1:0]  grant_o;

   int n_checks = 0;
   int n_fail   = 0;

   wb_mem_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_adr_i = 32'h0; m0_dat_i = 32'h0; m0_sel_i = 4'h0; m0_we_i = 1'b0;
      m0_cyc_i = 1'b0;  m0_stb_i = 1'b0;
      m1_adr_i = 32'h0; m1_dat_i = 32'h0; m1_sel_i = 4'h0; m1_we_i = 1'b0;
      m1_cyc_i = 1'b0;  m1_stb_i = 1'b0;
      s_dat_i  = 32'h0; s_ack_i  = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // m0 write outside the window: no slave strobe, one err pulse, grant kept.
   task automatic illegal_write(input string tag, input logic [31:0] adr, input logic [31:0] exp_off);
      m0_adr_i = adr; m0_dat_i = 32'h1111_2222; m0_sel_i = 4'hF; m0_we_i = 1'b1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      tick();
      check_val({tag, "_g0_grant"}, 32'(grant_o), 32'h1);
      check_val({tag, "_g0_sstb"}, 32'(s_stb_o), 32'h0);
      check_val({tag, "_g0_scyc"}, 32'(s_cyc_o), 32'h1);
      check_val({tag, "_g0_sadr"}, s_adr_o, exp_off);
      check_val({tag, "_g0_err"}, 32'(m0_err_o), 32'h0);
      tick();
      check_val({tag, "_err_m0err"}, 32'(m0_err_o), 32'h1);
      check_val({tag, "_err_m1err"}, 32'(m1_err_o), 32'h0);
      check_val({tag, "_err_scyc"}, 32'(s_cyc_o), 32'h0);
      check_val({tag, "_err_sstb"}, 32'(s_stb_o), 32'h0);
      check_val({tag, "_err_grant"}, 32'(grant_o), 32'h1);
      m0_stb_i = 1'b0;
      tick();
      check_val({tag, "_back_err"}, 32'(m0_err_o), 32'h0);
      check_val({tag, "_back_grant"}, 32'(grant_o), 32'h1);
      check_val({tag, "_back_sstb"}, 32'(s_stb_o), 32'h0);
      m0_cyc_i = 1'b0; m0_we_i = 1'b0;
      tick();
      check_val({tag, "_idle_grant"}, 32'(grant_o), 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      check_val("rst_grant", 32'(grant_o), 32'h0);
      check_val("rst_scyc", 32'(s_cyc_o), 32'h0);
      check_val("rst_sstb", 32'(s_stb_o), 32'h0);
      check_val("rst_sadr", s_adr_o, 32'h0);
      check_val("rst_m0ack", 32'(m0_ack_o), 32'h0);
      check_val("rst_m1err", 32'(m1_err_o), 32'h0);
      reset = 1'b0;

      // Single m1 read, slave acks one cycle after the grant.
      m1_adr_i = 32'h8000_0010; m1_sel_i = 4'hF; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      check_val("rd_grant", 32'(grant_o), 32'h2);
      check_val("rd_sadr", s_adr_o, 32'h10);
      check_val("rd_sstb", 32'(s_stb_o), 32'h1);
      check_val("rd_m1ack_early", 32'(m1_ack_o), 32'h0);
      tick();
      s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1'b1;
      #1;
      check_val("rd_m1ack", 32'(m1_ack_o), 32'h1);
      check_val("rd_m1dat", m1_dat_o, 32'hDEAD_BEEF);
      check_val("rd_m0ack", 32'(m0_ack_o), 32'h0);
      check_val("rd_m0dat", m0_dat_o, 32'h0);
      tick();
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
      #1;
      check_val("rd_m1ack_drop", 32'(m1_ack_o), 32'h0);
      tick();
      check_val("rd_idle_grant", 32'(grant_o), 32'h0);

      // Simultaneous requests right after reset.
      do_reset();
      m0_adr_i = 32'h8000_0100; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      m1_adr_i = 32'h8000_0200; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      check_val("tie_first_grant", 32'(grant_o), 32'h1);
      check_val("tie_first_sadr", s_adr_o, 32'h100);
      s_ack_i = 1'b1;
      #1;
      check_val("tie_m0ack", 32'(m0_ack_o), 32'h1);
      check_val("tie_m1ack", 32'(m1_ack_o), 32'h0);
      tick();
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
      tick();
      check_val("tie_gap_grant", 32'(grant_o), 32'h0);
      tick();
      check_val("tie_second_grant", 32'(grant_o), 32'h2);
      check_val("tie_second_sadr", s_adr_o, 32'h200);
      s_ack_i = 1'b1;
      tick();
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
      tick();
      m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
      tick();
      check_val("tie_third_grant", 32'(grant_o), 32'h1);
      m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
      tick();

      // m0 burst of four strobes inside one cyc while m1 waits.
      m0_adr_i = 32'h8000_0040; m0_sel_i = 4'h3; m0_we_i = 1'b1; m0_cyc_i = 1'b1;
      tick();
      m1_adr_i = 32'h8000_0080; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m0_stb_i = 1'b1; m0_dat_i = 32'hA5A5_0000 + 32'(i); s_ack_i = 1'b1;
         #1;
         check_val("burst_grant", 32'(grant_o), 32'h1);
         check_val("burst_m0ack", 32'(m0_ack_o), 32'h1);
         check_val("burst_sdat", s_dat_o, 32'hA5A5_0000 + 32'(i));
         tick();
         m0_stb_i = 1'b0; s_ack_i = 1'b0;
         #1;
         check_val("burst_hold_grant", 32'(grant_o), 32'h1);
         tick();
      end
      check_val("burst_swe", 32'(s_we_o), 32'h1);
      check_val("burst_ssel", 32'(s_sel_o), 32'h3);
      m0_cyc_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = 4'h0;
      tick();
      check_val("burst_gap_grant", 32'(grant_o), 32'h0);
      tick();
      check_val("burst_m1_grant", 32'(grant_o), 32'h2);
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      tick();

      illegal_write("above", 32'h8001_0000, 32'h0001_0000);
      illegal_write("below", 32'h7FFF_FFFC, 32'hFFFF_FFFC);

      // Slave never acks: err on the ninth cycle of the strobe, late ack ignored.
      m1_adr_i = 32'h8000_0020; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      check_val("to_c1_sstb", 32'(s_stb_o), 32'h1);
      for (int k = 2; k <= 8; k++) begin
         tick();
         check_val("to_wait_err", 32'(m1_err_o), 32'h0);
         check_val("to_wait_sstb", 32'(s_stb_o), 32'h1);
      end
      tick();
      check_val("to_c9_err", 32'(m1_err_o), 32'h1);
      check_val("to_c9_scyc", 32'(s_cyc_o), 32'h0);
      s_ack_i = 1'b1;
      #1;
      check_val("to_late_ack", 32'(m1_ack_o), 32'h0);
      m1_stb_i = 1'b0; s_ack_i = 1'b0;
      tick();
      check_val("to_back_err", 32'(m1_err_o), 32'h0);
      check_val("to_back_grant", 32'(grant_o), 32'h2);
      m1_cyc_i = 1'b0;
      tick();

      // Ack arriving in the same cycle the counter reaches its last value.
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      for (int k = 2; k <= 8; k++) tick();
      s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
      #1;
      check_val("ackedge_ack", 32'(m1_ack_o), 32'h1);
      check_val("ackedge_dat", m1_dat_o, 32'h1234_5678);
      check_val("ackedge_err", 32'(m1_err_o), 32'h0);
      tick();
      m1_stb_i = 1'b0; s_ack_i = 1'b0;
      #1;
      check_val("ackedge_after_err", 32'(m1_err_o), 32'h0);
      check_val("ackedge_after_grant", 32'(grant_o), 32'h2);
      tick();
      check_val("ackedge_after2_err", 32'(m1_err_o), 32'h0);
      m1_cyc_i = 1'b0;
      tick();

      // Reset in the middle of a pending m1 access.
      m1_adr_i = 32'h8000_0030; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      check_val("rstmid_sstb_before", 32'(s_stb_o), 32'h1);
      reset = 1'b1;
      tick();
      check_val("rstmid_grant", 32'(grant_o), 32'h0);
      check_val("rstmid_scyc", 32'(s_cyc_o), 32'h0);
      check_val("rstmid_sstb", 32'(s_stb_o), 32'h0);
      check_val("rstmid_sadr", s_adr_o, 32'h0);
      check_val("rstmid_m1ack", 32'(m1_ack_o), 32'h0);
      reset = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val("rstmid_post_ack", 32'(m1_ack_o), 32'h0);
         check_val("rstmid_post_err", 32'(m1_err_o), 32'h0);
         check_val("rstmid_post_grant", 32'(grant_o), 32'h0);
      end
      s_ack_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
